aes_ecb_axil_regs: RTL and testbench

- AXI4-Lite slave (responder) register front-end for the AES-ECB accelerator.
- Terminates the S00_AXI port driven by the PS/master VIP.
- Holds the 128-bit key, 128-bit input block, control and status registers.
- Launches the AES core, captures its 128-bit result into read-only registers and raises an interrupt on completion.

---
 rtl/aes_ecb_axil_regs.sv | 192 +++++++++++++++++++
 tb/tb_aes_ecb_axil_regs.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ecb_axil_regs.sv
// rtl/aes_ecb_axil_regs.sv - AXI4-Lite register front-end for the AES-ECB core
//   s00_axi_*    : AXI4-Lite responder, 32-bit data, 6-bit byte address
//   core_start   : one-cycle launch pulse; core_decrypt/core_key/core_din held while busy
//   core_done    : one-cycle completion pulse, core_dout captured on it
//   irq          : level interrupt, DONE & IRQ_EN (registered)
module aes_ecb_axil_regs #(
    parameter int          C_S00_AXI_DATA_WIDTH = 32,
    parameter int          C_S00_AXI_ADDR_WIDTH = 6,
    parameter logic [31:0] VERSION              = 32'h0001_0000
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              core_start,
    output logic                              core_decrypt,
    output logic [127:0]                      core_key,
    output logic [127:0]                      core_din,
    input  logic                              core_done,
    input  logic [127:0]                      core_dout,
    output logic                              irq
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [31:0] key_q  [4];
    logic [31:0] din_q  [4];
    logic [31:0] dout_q [4];
    logic        mode_q, irq_en_q, busy_q, done_q;

    logic [3:0]  wr_idx, rd_idx;
    logic [31:0] wmask;
    logic        wr_fire, rd_fire;
    logic        wr_err, wr_key, wr_din, wr_ctrl, wr_w1c;
    logic        launch, done_set;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    // Protection bits and the byte offset within a word carry no meaning here.
    wire unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction

    assign wr_idx   = s00_axi_awaddr[5:2];
    assign rd_idx   = s00_axi_araddr[5:2];
    assign wmask    = {{8{s00_axi_wstrb[3]}}, {8{s00_axi_wstrb[2]}},
                       {8{s00_axi_wstrb[1]}}, {8{s00_axi_wstrb[0]}}};
    assign wr_fire  = s00_axi_awready && s00_axi_awvalid && s00_axi_wready && s00_axi_wvalid;
    assign rd_fire  = s00_axi_arready && s00_axi_arvalid;
    // START only counts when its byte lane is enabled; wr_ctrl is already false while busy.
    assign launch   = wr_fire && wr_ctrl && s00_axi_wstrb[0] && s00_axi_wdata[0];
    assign done_set = core_done && busy_q;

    always_comb begin
        wr_err  = 1'b0;
        wr_key  = 1'b0;
        wr_din  = 1'b0;
        wr_ctrl = 1'b0;
        wr_w1c  = 1'b0;
        case (wr_idx)
            4'd0, 4'd1, 4'd2, 4'd3: if (busy_q) wr_err = 1'b1; else wr_key = 1'b1;
            4'd4, 4'd5, 4'd6, 4'd7: if (busy_q) wr_err = 1'b1; else wr_din = 1'b1;
            4'd8:                   if (busy_q) wr_err = 1'b1; else wr_ctrl = 1'b1;
            4'd9: begin
                // Only the DONE bit is writable in STATUS; anything else rejects the write.
                if ((s00_axi_wdata & wmask & ~32'h2) != 32'h0) wr_err = 1'b1;
                else wr_w1c = s00_axi_wstrb[0] && s00_axi_wdata[1];
            end
            default:                wr_err = 1'b1;
        endcase
    end

    always_comb begin
        rd_data = 32'h0;
        rd_resp = RESP_OKAY;
        case (rd_idx)
            4'd0, 4'd1, 4'd2, 4'd3: rd_data = key_q[rd_idx[1:0]];
            4'd4, 4'd5, 4'd6, 4'd7: rd_data = din_q[rd_idx[1:0]];
            4'd8:  rd_data = {29'h0, irq_en_q, mode_q, 1'b0};
            4'd9:  rd_data = {30'h0, done_q, busy_q};
            4'd10: rd_data = dout_q[0];
            4'd11: rd_data = dout_q[1];
            4'd12: rd_data = dout_q[2];
            4'd13: rd_data = dout_q[3];
            4'd14: rd_data = VERSION;
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    // AXI handshakes: AW and W are accepted together with a single ready pulse.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= RESP_OKAY;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= 32'h0;
            s00_axi_rresp   <= RESP_OKAY;
        end else begin
            s00_axi_awready <= s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid &&
                               !(s00_axi_awready || s00_axi_wready);
            s00_axi_wready  <= s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid &&
                               !(s00_axi_awready || s00_axi_wready);
            if (wr_fire) begin
                s00_axi_bvalid <= 1'b1;
                s00_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s00_axi_bvalid && s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
            s00_axi_arready <= s00_axi_arvalid && !s00_axi_rvalid && !s00_axi_arready;
            if (rd_fire) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_data;
                s00_axi_rresp  <= rd_resp;
            end else if (s00_axi_rvalid && s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    // Register file, launch and completion tracking.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < 4; i++) begin
                key_q[i]  <= 32'h0;
                din_q[i]  <= 32'h0;
                dout_q[i] <= 32'h0;
            end
            mode_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            core_start <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (wr_fire && wr_key)
                key_q[wr_idx[1:0]] <= strb_merge(key_q[wr_idx[1:0]], s00_axi_wdata, s00_axi_wstrb);
            if (wr_fire && wr_din)
                din_q[wr_idx[1:0]] <= strb_merge(din_q[wr_idx[1:0]], s00_axi_wdata, s00_axi_wstrb);
            if (wr_fire && wr_ctrl && s00_axi_wstrb[0]) begin
                mode_q   <= s00_axi_wdata[1];
                irq_en_q <= s00_axi_wdata[2];
            end
            core_start <= launch;
            if (launch)        busy_q <= 1'b1;
            else if (done_set) busy_q <= 1'b0;
            // A completion in the same cycle as a W1C keeps DONE set.
            if (done_set)                              done_q <= 1'b1;
            else if (launch || (wr_fire && wr_w1c))    done_q <= 1'b0;
            if (done_set) begin
                dout_q[0] <= core_dout[127:96];
                dout_q[1] <= core_dout[95:64];
                dout_q[2] <= core_dout[63:32];
                dout_q[3] <= core_dout[31:0];
            end
            irq <= done_q && irq_en_q;
        end
    end

    assign core_decrypt = mode_q;
    assign core_key     = {key_q[0], key_q[1], key_q[2], key_q[3]};
    assign core_din     = {din_q[0], din_q[1], din_q[2], din_q[3]};

endmodule

// File: tb/tb_aes_ecb_axil_regs.sv
// tb/tb_aes_ecb_axil_regs.sv - scoreboard bench for aes_ecb_axil_regs
module tb_aes_ecb_axil_regs;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [5:0]   awaddr = '0, araddr = '0;
    logic [2:0]   awprot = '0, arprot = '0;
    logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [31:0]  wdata = '0, rdata;
    logic [3:0]   wstrb = '0;
    logic [1:0]   bresp, rresp;
    logic         core_start, core_decrypt, core_done = 0, irq;
    logic [127:0] core_key, core_din, core_dout = '0;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [1:0] b_q [$];
    rexp_t      r_q [$];
    int checks = 0, errors = 0;
    int aw_pulses = 0, start_pulses = 0;

    always #5 clk = ~clk;

    aes_ecb_axil_regs dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot),
        .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .core_start(core_start), .core_decrypt(core_decrypt),
        .core_key(core_key), .core_din(core_din),
        .core_done(core_done), .core_dout(core_dout), .irq(irq)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: pop expectations as B and R handshakes complete.
    always @(negedge clk) begin
        if (rst_n) begin
            if (awready) aw_pulses++;
            if (core_start) start_pulses++;
            if (bvalid && bready) begin
                check("b_expected", b_q.size() != 0, 1'b1);
                if (b_q.size() != 0) check("bresp", bresp, b_q.pop_front());
            end
            if (rvalid && rready) begin
                check("r_expected", r_q.size() != 0, 1'b1);
                if (r_q.size() != 0) begin
                    rexp_t e;
                    e = r_q.pop_front();
                    check($sformatf("rdata@%0h", e.addr), rdata, e.data);
                    check($sformatf("rresp@%0h", e.addr), rresp, e.resp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_aw(input string tag);
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (awready) ok = 1;
        end
        check(tag, ok, 1'b1);
        check({tag, "_wready"}, wready, ok);
    endtask

    task automatic wait_b();
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bvalid) ok = 1;
        end
        check("b_seen", ok, 1'b1);
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] exp, input int w_lead);
        b_q.push_back(exp);
        bready = 1;
        wdata = d; wstrb = s; wvalid = 1;
        repeat (w_lead) tick();
        awaddr = a; awvalid = 1;
        wait_aw("aw_accept");
        tick();
        awvalid = 0; wvalid = 0;
        wait_b();
        tick();
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] d, input logic [1:0] resp);
        bit ok = 0;
        rexp_t e;
        e.addr = a; e.data = d; e.resp = resp;
        r_q.push_back(e);
        rready = 1;
        araddr = a; arvalid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (arready) ok = 1;
        end
        check("ar_accept", ok, 1'b1);
        tick();
        arvalid = 0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rvalid) ok = 1;
        end
        check("r_seen", ok, 1'b1);
        tick();
    endtask

    task automatic pulse_done(input logic [127:0] v);
        core_dout = v; core_done = 1;
        tick();
        core_done = 0; core_dout = ~v;
    endtask

    localparam logic [127:0] V1 = 128'h3925841D_02DC09FB_DC118597_196A0B32;
    localparam logic [127:0] V2 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    initial begin
        int p0, s0;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_handshakes", {awready, wready, bvalid, arready, rvalid, core_start, irq}, 7'h0);
        check("rst_resp", {bresp, rresp}, 4'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_key", core_key, 128'h0);
        tick();
        rst_n = 1;
        tick();

        // Key registers, version, status
        for (int i = 0; i < 4; i++) axi_write(6'(4*i), 32'(i + 1), 4'hF, OKAY, 0);
        for (int i = 0; i < 4; i++) axi_read(6'(4*i), 32'(i + 1), OKAY);
        axi_read(6'h38, 32'h0001_0000, OKAY);
        axi_read(6'h24, 32'h0, OKAY);

        // W ahead of AW
        p0 = aw_pulses;
        axi_write(6'h18, 32'hDEADBEEF, 4'hF, OKAY, 3);
        check("aw_pulse_once", aw_pulses - p0, 1);
        axi_read(6'h18, 32'hDEADBEEF, OKAY);

        // Byte strobes
        axi_write(6'h04, 32'hAABBCCDD, 4'b0101, OKAY, 0);
        axi_read(6'h04, 32'h00BB00DD, OKAY);

        // Launch, writes while busy, completion
        s0 = start_pulses;
        axi_write(6'h20, 32'h5, 4'hF, OKAY, 0);
        check("start_pulse", start_pulses - s0, 1);
        axi_read(6'h24, 32'h1, OKAY);
        check("core_key", core_key, {32'h1, 32'h00BB00DD, 32'h3, 32'h4});
        check("core_din", core_din, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
        check("core_decrypt0", core_decrypt, 1'b0);
        axi_write(6'h20, 32'h0, 4'hF, SLVERR, 0);
        axi_read(6'h20, 32'h4, OKAY);
        axi_write(6'h00, 32'hFFFFFFFF, 4'hF, SLVERR, 0);
        check("core_key_busy", core_key, {32'h1, 32'h00BB00DD, 32'h3, 32'h4});
        check("start_once", start_pulses - s0, 1);
        pulse_done(V1);
        tick();
        axi_read(6'h24, 32'h2, OKAY);
        axi_read(6'h28, 32'h3925841D, OKAY);
        axi_read(6'h34, 32'h196A0B32, OKAY);
        check("irq_set", irq, 1'b1);

        // Second launch (decrypt) with W1C colliding with core_done
        axi_write(6'h20, 32'h7, 4'hF, OKAY, 0);
        check("core_decrypt1", core_decrypt, 1'b1);
        tick();
        check("irq_clr_launch", irq, 1'b0);
        b_q.push_back(OKAY);
        bready = 1;
        awaddr = 6'h24; wdata = 32'h2; wstrb = 4'h1; awvalid = 1; wvalid = 1;
        tick();
        core_done = 1; core_dout = V2;
        @(negedge clk);
        check("collide_awready", awready, 1'b1);
        tick();
        core_done = 0; awvalid = 0; wvalid = 0;
        wait_b();
        tick();
        axi_read(6'h24, 32'h2, OKAY);
        axi_read(6'h2C, 32'h44556677, OKAY);
        check("irq_after_collide", irq, 1'b1);
        axi_write(6'h24, 32'h2, 4'h1, OKAY, 0);
        axi_read(6'h24, 32'h0, OKAY);
        check("irq_after_w1c", irq, 1'b0);

        // Error responses
        axi_read(6'h3C, 32'h0, SLVERR);
        axi_write(6'h3C, 32'h1, 4'hF, SLVERR, 0);
        axi_write(6'h28, 32'hFFFFFFFF, 4'hF, SLVERR, 0);
        axi_read(6'h28, 32'h00112233, OKAY);
        axi_write(6'h24, 32'h3, 4'h1, SLVERR, 0);
        axi_read(6'h20, 32'h6, OKAY);

        // Back-pressure on B with a second write waiting
        bready = 0;
        b_q.push_back(OKAY);
        awaddr = 6'h00; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        wait_aw("bp_aw1");
        tick();
        b_q.push_back(OKAY);
        wdata = 32'h22222222;
        wait_b();
        p0 = aw_pulses;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bvalid_hold", bvalid, 1'b1);
            check("bresp_hold", bresp, OKAY);
        end
        check("no_aw_while_b", aw_pulses - p0, 0);
        tick();
        bready = 1;
        wait_aw("bp_aw2");
        tick();
        awvalid = 0; wvalid = 0;
        wait_b();
        tick();
        axi_read(6'h00, 32'h22222222, OKAY);

        // Reset while busy, then a stray core_done
        s0 = start_pulses;
        axi_write(6'h20, 32'h1, 4'hF, OKAY, 0);
        check("start_pre_reset", start_pulses - s0, 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        check("core_start_post_reset", core_start, 1'b0);
        axi_read(6'h24, 32'h0, OKAY);
        axi_read(6'h00, 32'h0, OKAY);
        pulse_done(V1);
        tick();
        axi_read(6'h24, 32'h0, OKAY);
        axi_read(6'h28, 32'h0, OKAY);
        check("start_total", start_pulses - s0, 1);
        check("queues_drained", b_q.size() + r_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
